// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Unified-memory request/ready handshake between the
//               multi-cycle sequencer (master) and memory (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
    logic mem_req;      // access active
    logic mem_read;     // data load
    logic mem_write;    // data store
    logic mem_ready;    // memory completes the current access this cycle

    modport master (output mem_req, output mem_read, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_read, input mem_write, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle RV32 sequencer. Steps the shared datapath through
//               fetch/decode/execute/memory/write-back, counts retired
//               instructions and traps on illegal opcodes or memory timeout.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        mem,
    input  logic [6:0]                  opcode,
    input  logic                        branch_taken,
    output logic                        ir_write,
    output logic                        alu_src,
    output logic [3:0]                  alu_op,
    output logic                        reg_write,
    output logic [1:0]                  mem_to_reg,
    output logic                        branch,
    output logic                        pc_write,
    output logic [1:0]                  pc_src,
    output logic                        instr_done,
    output logic [31:0]                 instr_count,
    output logic                        illegal,
    output logic                        bus_error
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_ALU = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_MEM = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [6:0] c_op_r     = 7'b0110011;
    localparam logic [6:0] c_op_i     = 7'b0010011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_br    = 7'b1100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    // Counter value on the last permitted wait cycle; not-ready here traps.
    localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic        r_is_load;
    logic        r_mem_req, r_mem_read, r_mem_write;
    logic        r_alu_src;
    logic [3:0]  r_alu_op;
    logic        r_reg_write;
    logic [1:0]  r_mem_to_reg;
    logic        r_branch;
    logic        r_pc_write;
    logic [1:0]  r_pc_src;
    logic        r_retire;
    logic [31:0] r_instr_count;
    logic        r_illegal;
    logic        r_bus_error;
    logic        w_in_wait;
    logic        w_timeout;
    logic        w_store_done;

    assign w_in_wait    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout    = w_in_wait && !mem.mem_ready && (r_wait_cnt == c_wait_last);
    assign w_store_done = (r_state == S_MEM_WR) && mem.mem_ready;

    // Next-state selection; ready beats timeout on the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    c_op_r:                w_next = S_EXEC_R;
                    c_op_i:                w_next = S_EXEC_I;
                    c_op_load, c_op_store: w_next = S_ADDR;
                    c_op_br:               w_next = S_BRANCH;
                    c_op_jal:              w_next = S_JAL;
                    c_op_jalr:             w_next = S_JALR;
                    default:               w_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_ADDR:   w_next = r_is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem.mem_ready)  w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem.mem_ready)  w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, bookkeeping and Moore outputs registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_is_load     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_op      <= 4'b0000;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 2'b00;
            r_branch      <= 1'b0;
            r_pc_write    <= 1'b0;
            r_pc_src      <= 2'b00;
            r_retire      <= 1'b0;
            r_instr_count <= '0;
            r_illegal     <= 1'b0;
            r_bus_error   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_in_wait && !mem.mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
            else                                          r_wait_cnt <= '0;

            // opcode is only trusted in DECODE, so remember load vs store here.
            if (r_state == S_DECODE) r_is_load <= (opcode == c_op_load);
            if (r_state == S_DECODE && w_next == S_TRAP) r_illegal <= 1'b1;
            if (w_timeout) r_bus_error <= 1'b1;
            if (instr_done) r_instr_count <= r_instr_count + 32'd1;

            r_mem_req    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 2'b00;
            r_branch     <= 1'b0;
            r_pc_write   <= 1'b0;
            r_pc_src     <= 2'b00;
            r_retire     <= 1'b0;
            // WB_ALU keeps whatever ALU setup its EXEC state chose.
            if (w_next != S_WB_ALU) begin
                r_alu_op  <= 4'b0000;
                r_alu_src <= 1'b0;
            end

            case (w_next)
                S_FETCH:  r_mem_req <= 1'b1;
                S_EXEC_R: begin r_alu_op <= 4'b0010; r_alu_src <= 1'b0; end
                S_EXEC_I: begin r_alu_op <= 4'b0011; r_alu_src <= 1'b1; end
                S_WB_ALU: begin r_reg_write <= 1'b1; r_pc_write <= 1'b1; r_retire <= 1'b1; end
                S_ADDR:   r_alu_src <= 1'b1;
                S_MEM_RD: begin r_mem_req <= 1'b1; r_mem_read <= 1'b1; r_alu_src <= 1'b1; end
                S_WB_MEM: begin
                    r_reg_write <= 1'b1; r_mem_to_reg <= 2'b01; r_pc_write <= 1'b1; r_retire <= 1'b1;
                end
                S_MEM_WR: begin r_mem_req <= 1'b1; r_mem_write <= 1'b1; r_alu_src <= 1'b1; end
                S_BRANCH: begin
                    r_branch <= 1'b1; r_alu_op <= 4'b0001; r_pc_write <= 1'b1; r_retire <= 1'b1;
                end
                S_JAL: begin
                    r_reg_write <= 1'b1; r_mem_to_reg <= 2'b10; r_pc_write <= 1'b1;
                    r_pc_src <= 2'b01; r_retire <= 1'b1;
                end
                S_JALR: begin
                    r_alu_src <= 1'b1; r_reg_write <= 1'b1; r_mem_to_reg <= 2'b10;
                    r_pc_write <= 1'b1; r_pc_src <= 2'b10; r_retire <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Wait-state strobes are qualified by the live ready; branch target by the live compare.
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_read  = r_mem_read;
    assign mem.mem_write = r_mem_write;
    assign ir_write      = (r_state == S_FETCH) && mem.mem_ready;
    assign alu_src       = r_alu_src;
    assign alu_op        = r_alu_op;
    assign reg_write     = r_reg_write;
    assign mem_to_reg    = r_mem_to_reg;
    assign branch        = r_branch;
    assign pc_write      = r_pc_write | w_store_done;
    assign pc_src        = {r_pc_src[1], r_pc_src[0] | (r_branch & branch_taken)};
    assign instr_done    = r_retire | w_store_done;
    assign instr_count   = r_instr_count;
    assign illegal       = r_illegal;
    assign bus_error     = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control with
//               hand-computed control vectors per state.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        ir_write, alu_src, reg_write, branch, pc_write, instr_done, illegal, bus_error;
    logic [3:0]  alu_op;
    logic [1:0]  mem_to_reg, pc_src;
    logic [31:0] instr_count;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus.master),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .ir_write     (ir_write),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .branch       (branch),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .instr_done   (instr_done),
        .instr_count  (instr_count),
        .illegal      (illegal),
        .bus_error    (bus_error)
    );

    assign obs = {bus.mem_req, bus.mem_read, bus.mem_write, ir_write, alu_src, alu_op,
                  reg_write, mem_to_reg, branch, pc_write, pc_src, instr_done};

    // Expected control vector, fields in the same order as obs.
    function automatic logic [16:0] ctl(input logic req, input logic rd, input logic wr,
                                        input logic irw, input logic src, input logic [3:0] op,
                                        input logic rw, input logic [1:0] m2r, input logic br,
                                        input logic pcw, input logic [1:0] pcs, input logic done);
        return {req, rd, wr, irw, src, op, rw, m2r, br, pcw, pcs, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive inputs after the falling edge, sample 1ns later.
    task automatic step(input logic mr, input logic bt);
        @(negedge clk);
        bus.mem_ready = mr;
        branch_taken  = bt;
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; branch_taken = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl",  32'(obs), 32'd0);
        check("rst_cnt",  instr_count, 32'd0);
        check("rst_ill",  32'(illegal), 32'd0);
        check("rst_berr", 32'(bus_error), 32'd0);
        rst = 1'b0;                                           // IDLE cycle
        check("idle_ctl", 32'(obs), 32'd0);

        // R-type, zero wait
        opcode = OP_R;
        step(1, 0); check("r_fetch",  32'(obs), 32'(ctl(1,0,0,1,0,4'b0000,0,2'b00,0,0,2'b00,0)));
        step(1, 0); check("r_decode", 32'(obs), 32'd0);
        step(1, 0); check("r_exec",   32'(obs), 32'(ctl(0,0,0,0,0,4'b0010,0,2'b00,0,0,2'b00,0)));
        step(1, 0); check("r_wb",     32'(obs), 32'(ctl(0,0,0,0,0,4'b0010,1,2'b00,0,1,2'b00,1)));
        check("r_cnt_pre", instr_count, 32'd0);

        // Load with 3 wait cycles in MEM_RD; ready on the last permitted cycle
        opcode = OP_LOAD;
        step(1, 0); check("r_cnt", instr_count, 32'd1);
        step(1, 0);
        step(0, 0); check("ld_addr", 32'(obs), 32'(ctl(0,0,0,0,1,4'b0000,0,2'b00,0,0,2'b00,0)));
        for (int i = 0; i < 3; i++) begin
            step(0, 0); check("ld_wait", 32'(obs), 32'(ctl(1,1,0,0,1,4'b0000,0,2'b00,0,0,2'b00,0)));
        end
        step(1, 0); check("ld_rdy", 32'(obs), 32'(ctl(1,1,0,0,1,4'b0000,0,2'b00,0,0,2'b00,0)));
        step(0, 0); check("ld_wb",  32'(obs), 32'(ctl(0,0,0,0,0,4'b0000,1,2'b01,0,1,2'b00,1)));

        // Store with one wait cycle
        opcode = OP_STORE;
        step(1, 0); check("ld_cnt", instr_count, 32'd2);
        step(1, 0);
        step(1, 0);
        step(0, 0); check("st_wait", 32'(obs), 32'(ctl(1,0,1,0,1,4'b0000,0,2'b00,0,0,2'b00,0)));
        step(1, 0); check("st_rdy",  32'(obs), 32'(ctl(1,0,1,0,1,4'b0000,0,2'b00,0,1,2'b00,1)));

        // Branch taken, then not taken
        opcode = OP_BR;
        step(1, 0); check("st_cnt", instr_count, 32'd3);
        step(1, 0);
        step(1, 1); check("br_taken", 32'(obs), 32'(ctl(0,0,0,0,0,4'b0001,0,2'b00,1,1,2'b01,1)));
        step(1, 0);
        step(1, 0);
        step(1, 0); check("br_not",   32'(obs), 32'(ctl(0,0,0,0,0,4'b0001,0,2'b00,1,1,2'b00,1)));

        opcode = OP_JAL;
        step(1, 0); step(1, 0);
        step(1, 0); check("jal",  32'(obs), 32'(ctl(0,0,0,0,0,4'b0000,1,2'b10,0,1,2'b01,1)));
        opcode = OP_JALR;
        step(1, 0); step(1, 0);
        step(1, 0); check("jalr", 32'(obs), 32'(ctl(0,0,0,0,1,4'b0000,1,2'b10,0,1,2'b10,1)));

        // Illegal opcode -> TRAP, held for 20 cycles
        opcode = 7'b0000000;
        step(1, 0); check("pre_ill_cnt", instr_count, 32'd7);
        step(1, 0); check("dec_ill", 32'(illegal), 32'd0);
        step(1, 0); check("trap_ill", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1); check("trap_ctl", 32'(obs), 32'd0);
        end
        check("trap_cnt", instr_count, 32'd7);
        check("trap_berr", 32'(bus_error), 32'd0);
        rst = 1'b1;
        step(0, 0);
        check("trst_ill", 32'(illegal), 32'd0);
        check("trst_cnt", instr_count, 32'd0);
        check("trst_ctl", 32'(obs), 32'd0);
        rst = 1'b0;

        // Fetch timeout after 4 wait cycles
        opcode = OP_R;
        for (int i = 0; i < 4; i++) begin
            step(0, 0); check("to_fetch", 32'(obs), 32'(ctl(1,0,0,0,0,4'b0000,0,2'b00,0,0,2'b00,0)));
            check("to_berr0", 32'(bus_error), 32'd0);
        end
        step(0, 0);
        check("to_berr1", 32'(bus_error), 32'd1);
        check("to_ctl", 32'(obs), 32'd0);
        rst = 1'b1;
        step(0, 0); check("to_rst", 32'(bus_error), 32'd0);
        rst = 1'b0;

        // Ready on the 4th wait cycle wins
        step(0, 0); step(0, 0); step(0, 0);
        step(1, 0); check("rdy4_fetch", 32'(obs), 32'(ctl(1,0,0,1,0,4'b0000,0,2'b00,0,0,2'b00,0)));
        step(0, 0); check("rdy4_dec", 32'(obs), 32'd0);
        check("rdy4_berr", 32'(bus_error), 32'd0);
        step(0, 0); check("rdy4_exec", 32'(obs), 32'(ctl(0,0,0,0,0,4'b0010,0,2'b00,0,0,2'b00,0)));
        step(0, 0);
        step(1, 0); check("rdy4_cnt", instr_count, 32'd1);

        // Counter wrap
        dut.r_instr_count = 32'hFFFF_FFFF;
        step(1, 0);
        step(1, 0);
        step(1, 0); check("wrap_done", 32'(instr_done), 32'd1);
        step(1, 0); check("wrap_cnt", instr_count, 32'd0);

        // Reset in the middle of a MEM_RD wait
        opcode = OP_LOAD;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0); check("mrd_wait", 32'(obs), 32'(ctl(1,1,0,0,1,4'b0000,0,2'b00,0,0,2'b00,0)));
        rst = 1'b1;
        step(0, 0);
        check("mrd_rst_ctl", 32'(obs), 32'd0);
        check("mrd_rst_cnt", instr_count, 32'd0);
        rst = 1'b0;
        step(1, 0); check("mrd_refetch", 32'(obs), 32'(ctl(1,0,0,1,0,4'b0000,0,2'b00,0,0,2'b00,0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 32-bit RISC-V core: it replaces the single-cycle opcode decoder with a state machine that steps the shared datapath through fetch, decode, execute, memory and write-back. It uses one memory port with a ready handshake and counts retired instructions. It traps on unsupported opcodes or a stalled memory. It sits between the instruction register/ALU/register file/PC and the unified memory.

## Interface
- MEM_TIMEOUT, 16, max consecutive wait cycles on one memory access before bus error; range 1..255
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instruction-register bits [6:0], valid from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- branch_taken  in  1  ALU compare result for current branch (funct3 decoded in ALU)
- mem_req  out  1  memory access active
- mem_read / mem_write  out  1  data load / data store access (both 0 during fetch)
- ir_write  out  1  latch fetched word into IR
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  4  0000 ADD, 0001 BRANCH-compare, 0010 R-type (funct decode), 0011 I-type (funct decode)
- reg_write  out  1  register-file write enable
- mem_to_reg  out  2  00 ALU result, 01 memory data, 10 PC+4
- branch  out  1  branch instruction in execute
- pc_write  out  1  update PC this cycle
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result (jalr)
- instr_done  out  1  one-cycle pulse on retire
- instr_count  out  32  retired-instruction count, wraps 0xFFFFFFFF -> 0
- illegal  out  1  sticky: unsupported opcode
- bus_error  out  1  sticky: memory timeout

## Operation
- All control outputs are Moore functions of state (pc_src in BRANCH also depends on branch_taken, and the write/pc_write/ir_write signals in wait states are qualified by mem_ready). Every output not listed for a state is 0.
- IDLE: reset state, all outputs 0 -> FETCH.
- FETCH: mem_req=1. If mem_ready: ir_write=1 -> DECODE; else stay.
- DECODE: no outputs. Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - other -> TRAP with illegal=1
- EXEC_R: alu_op=0010, alu_src=0 -> WB_ALU.
- EXEC_I: alu_op=0011, alu_src=1 -> WB_ALU.
- WB_ALU: holds the EXEC alu_op/alu_src; reg_write=1, mem_to_reg=00, pc_write=1, pc_src=00, retire -> FETCH.
- ADDR: alu_op=0000, alu_src=1 -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, mem_read=1, alu_op=0000, alu_src=1. If mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=01, pc_write=1, pc_src=00, retire -> FETCH.
- MEM_WR: mem_req=1, mem_write=1, alu_op=0000, alu_src=1. If mem_ready: pc_write=1, pc_src=00, retire -> FETCH.
- BRANCH: branch=1, alu_op=0001, alu_src=0, pc_write=1, pc_src=branch_taken?01:00, retire -> FETCH.
- JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=01, retire -> FETCH.
- JALR: alu_op=0000, alu_src=1, reg_write=1, mem_to_reg=10, pc_write=1, pc_src=10, retire -> FETCH.
- TRAP: all control outputs 0, illegal/bus_error held; stays until rst.
- Retire: instr_done=1 that cycle; instr_count increments on the following edge.
- Wait counter (8-bit): cleared on entry to FETCH/MEM_RD/MEM_WR and increments each cycle there with mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready=0 -> TRAP, bus_error=1. No writes occur on that cycle.

## Timing
- Reset: a rising edge with rst=1 gives state=IDLE, instr_count=0, illegal=bus_error=0, wait counter 0, all outputs 0. This applies from any state, including mid-wait and TRAP.
- After rst falls: one IDLE cycle, then FETCH.
- Zero-wait latency, FETCH entry to next FETCH:
  - R/I: 4
  - load: 5
  - store: 4
  - branch/jal/jalr: 3
- Each memory wait cycle adds 1.
- mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT: ready wins, normal transition.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- opcode is sampled only in DECODE.

## Test plan
- Reset then R-type (opcode 0110011), mem_ready tied 1: FETCH, DECODE, EXEC_R, WB_ALU, with reg_write=1 and mem_to_reg=00 in cycle 4. instr_count=1 after.
- Load (0000011), mem_ready low 3 cycles in MEM_RD: 8-cycle instruction; WB_MEM has reg_write=1, mem_to_reg=01. Store (0100011): mem_write=1, reg_write never 1.
- Branch (1100011) with branch_taken=1 then 0: pc_src=01 then 00, branch=1, 3 cycles each. JAL gives pc_src=01, mem_to_reg=10. JALR gives pc_src=10, alu_src=1.
- Opcode 0000000: illegal=1 after DECODE, state held in TRAP for 20 cycles with no pc_write/reg_write. rst clears illegal and restarts at IDLE.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH: bus_error=1 after 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle: no error, DECODE entered.
- Run 0xFFFFFFFF retires (force counter), one more R-type: instr_count wraps to 0. rst asserted mid MEM_RD wait: next cycle IDLE, mem_req=0, count=0.
